// File: rtl/modulo_updown_counter_pkg.sv
// Shared types and parameter legality check for the modulo up/down counter.
package modulo_updown_counter_pkg;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } cnt_mode_e;

    // Legal ranges: 1 <= MAX_VAL <= 2**WIDTH-1, 1 <= STEP <= MAX_VAL, DIV >= 1.
    function automatic bit params_legal(int width, int max_val, int step, int div);
        return (width >= 1) && (width <= 30)
            && (max_val >= 1) && (max_val <= (1 << width) - 1)
            && (step >= 1) && (step <= max_val)
            && (div >= 1);
    endfunction

endpackage

// File: rtl/modulo_updown_counter_if.sv
// Control and status bundle of the modulo up/down counter.
interface modulo_updown_counter_if #(
    parameter int WIDTH = 4
);
    import modulo_updown_counter_pkg::*;

    logic             enable;
    logic             up_down;
    cnt_mode_e        mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_flags;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;
    logic             unf;

    modport master (
        output enable, up_down, mode, load, load_val, clr_flags,
        input  q, tc, ovf, unf
    );

    modport slave (
        input  enable, up_down, mode, load, load_val, clr_flags,
        output q, tc, ovf, unf
    );

endinterface

// File: rtl/modulo_updown_counter_tick_prescaler.sv
// Enable prescaler: one tick per DIV enabled cycles; the count holds while enable is low.
module tick_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic enable,
    output logic tick
);

    if (DIV == 1) begin : g_passthru
        logic w_unused;
        assign w_unused = ^{clk, reset, clr};
        assign tick     = enable;
    end else begin : g_div
        localparam int              CW   = $clog2(DIV);
        localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

        logic [CW-1:0] r_cnt;

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        always_ff @(posedge clk) begin
            if (reset || clr) begin
                r_cnt <= '0;
            end else if (enable) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
            end
        end

        assign tick = enable && (r_cnt == LAST);
    end

endmodule

// File: rtl/modulo_updown_counter.sv
// Parametrised modulo up/down counter with load, wrap/saturate, prescaler,
// terminal-count pulse and sticky overflow/underflow flags.
module modulo_updown_counter
    import modulo_updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 9,
    parameter int STEP    = 1,
    parameter int DIV     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    modulo_updown_counter_if.slave    bus
);

    if (!params_legal(WIDTH, MAX_VAL, STEP, DIV)) begin : g_bad_params
        $error("modulo_updown_counter: illegal parameters WIDTH=%0d MAX_VAL=%0d STEP=%0d DIV=%0d",
               WIDTH, MAX_VAL, STEP, DIV);
    end

    // One extra bit so q+STEP and q+MAX_VAL+1 never wrap silently.
    localparam int EW = WIDTH + 1;
    typedef logic [EW-1:0] ext_t;
    localparam ext_t MAX_X  = ext_t'(MAX_VAL);
    localparam ext_t STEP_X = ext_t'(STEP);
    localparam ext_t MOD_X  = ext_t'(MAX_VAL + 1);

    logic             w_tick;
    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_set;
    logic             w_unf_set;
    ext_t             w_q_x;
    ext_t             w_up_x;
    ext_t             w_ld_x;

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clr    (bus.load),
        .enable (bus.enable),
        .tick   (w_tick)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        w_q_x     = ext_t'(r_q);
        w_up_x    = w_q_x + STEP_X;
        w_ld_x    = ext_t'(bus.load_val);
        w_q_nxt   = r_q;
        w_tc_nxt  = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;

        if (bus.load) begin
            w_q_nxt = (w_ld_x > MAX_X) ? WIDTH'(MAX_VAL) : bus.load_val;
        end else if (w_tick) begin
            if (bus.up_down) begin
                if (w_up_x <= MAX_X) begin
                    w_q_nxt = WIDTH'(w_up_x);
                end else begin
                    w_tc_nxt  = 1'b1;
                    w_ovf_set = 1'b1;
                    w_q_nxt   = (bus.mode == WRAP) ? WIDTH'(w_up_x - MOD_X) : WIDTH'(MAX_VAL);
                end
            end else begin
                if (w_q_x >= STEP_X) begin
                    w_q_nxt = WIDTH'(w_q_x - STEP_X);
                end else begin
                    w_tc_nxt  = 1'b1;
                    w_unf_set = 1'b1;
                    w_q_nxt   = (bus.mode == WRAP) ? WIDTH'(w_q_x + MOD_X - STEP_X) : '0;
                end
            end
        end
    end

    // A new crossing in the same cycle as clr_flags leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q   <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_tc  <= w_tc_nxt;
            r_ovf <= w_ovf_set | (r_ovf & ~bus.clr_flags);
            r_unf <= w_unf_set | (r_unf & ~bus.clr_flags);
        end
    end

    assign bus.q   = r_q;
    assign bus.tc  = r_tc;
    assign bus.ovf = r_ovf;
    assign bus.unf = r_unf;

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Scoreboard bench: directed steps push hand-computed expectations, a monitor pops and compares.
module tb_modulo_updown_counter;
    import modulo_updown_counter_pkg::*;

    localparam int A = 0;   // WIDTH=4 MAX_VAL=9 STEP=1 DIV=1
    localparam int B = 1;   // WIDTH=4 MAX_VAL=9 STEP=2 DIV=3

    typedef struct {
        int         dut;
        logic [3:0] q;
        logic       tc;
        logic       ovf;
        logic       unf;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    modulo_updown_counter_if #(.WIDTH(4)) bus_a ();
    modulo_updown_counter_if #(.WIDTH(4)) bus_b ();

    modulo_updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .DIV(1)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    modulo_updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(2), .DIV(3)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input int dut, input logic rst, input logic en, input logic ud,
                        input cnt_mode_e md, input logic ld, input logic [3:0] lv,
                        input logic clr, input logic [3:0] eq, input logic etc,
                        input logic eo, input logic eu, input string name);
        exp_t e;
        @(posedge clk);
        #2;
        if (dut == A) begin
            rst_a = rst; bus_a.enable = en; bus_a.up_down = ud; bus_a.mode = md;
            bus_a.load = ld; bus_a.load_val = lv; bus_a.clr_flags = clr;
        end else begin
            rst_b = rst; bus_b.enable = en; bus_b.up_down = ud; bus_b.mode = md;
            bus_b.load = ld; bus_b.load_val = lv; bus_b.clr_flags = clr;
        end
        e.dut = dut; e.q = eq; e.tc = etc; e.ovf = eo; e.unf = eu; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: outputs are stable 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.dut == A) begin
                    check({e.name, " q"},   bus_a.q,   e.q);
                    check({e.name, " tc"},  4'(bus_a.tc),  4'(e.tc));
                    check({e.name, " ovf"}, 4'(bus_a.ovf), 4'(e.ovf));
                    check({e.name, " unf"}, 4'(bus_a.unf), 4'(e.unf));
                end else begin
                    check({e.name, " q"},   bus_b.q,   e.q);
                    check({e.name, " tc"},  4'(bus_b.tc),  4'(e.tc));
                    check({e.name, " ovf"}, 4'(bus_b.ovf), 4'(e.ovf));
                    check({e.name, " unf"}, 4'(bus_b.unf), 4'(e.unf));
                end
            end
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.enable = 1'b0; bus_a.up_down = 1'b1; bus_a.mode = WRAP;
        bus_a.load = 1'b0; bus_a.load_val = 4'd0; bus_a.clr_flags = 1'b0;
        bus_b.enable = 1'b0; bus_b.up_down = 1'b1; bus_b.mode = WRAP;
        bus_b.load = 1'b0; bus_b.load_val = 4'd0; bus_b.clr_flags = 1'b0;

        // 1: up count with wrap at MAX_VAL
        step(A, 1, 0, 1, WRAP, 0, 0, 0,  0, 0, 0, 0, "t1 reset");
        for (int i = 1; i <= 11; i++)
            step(A, 0, 1, 1, WRAP, 0, 0, 0, 4'(i % 10), i == 10, i >= 10, 0,
                 $sformatf("t1 up%0d", i));

        // 2: down wrap from 0, clear, set-wins-over-clear
        step(A, 1, 0, 0, WRAP, 0, 0, 0,  0, 0, 0, 0, "t2 reset");
        step(A, 0, 1, 0, WRAP, 0, 0, 0,  9, 1, 0, 1, "t2 down wrap");
        step(A, 0, 0, 0, WRAP, 0, 0, 1,  9, 0, 0, 0, "t2 clr");
        step(A, 0, 0, 0, WRAP, 1, 0, 0,  0, 0, 0, 0, "t2 load0");
        step(A, 0, 1, 0, WRAP, 0, 0, 1,  9, 1, 0, 1, "t2 clr vs set");

        // 3: saturate up
        step(A, 1, 0, 1, SATURATE, 0, 0, 0,  0, 0, 0, 0, "t3 reset");
        step(A, 0, 0, 1, SATURATE, 1, 8, 0,  8, 0, 0, 0, "t3 load8");
        step(A, 0, 1, 1, SATURATE, 0, 0, 0,  9, 0, 0, 0, "t3 tick1");
        step(A, 0, 1, 1, SATURATE, 0, 0, 0,  9, 1, 1, 0, "t3 tick2");
        step(A, 0, 1, 1, SATURATE, 0, 0, 0,  9, 1, 1, 0, "t3 tick3");
        step(A, 0, 0, 1, SATURATE, 0, 0, 0,  9, 0, 1, 0, "t3 hold");

        // 4: load clamp, load priority, saturate down
        step(A, 0, 0, 1, SATURATE, 1, 12, 0, 9, 0, 1, 0, "t4 load12");
        step(A, 0, 1, 1, SATURATE, 1, 3, 0,  3, 0, 1, 0, "t4 load wins");
        step(A, 0, 0, 1, SATURATE, 1, 15, 0, 9, 0, 1, 0, "t4 load15");
        step(A, 0, 0, 0, SATURATE, 1, 0, 0,  0, 0, 1, 0, "t4 load0");
        step(A, 0, 1, 0, SATURATE, 0, 0, 0,  0, 1, 1, 1, "t4 sat down");
        step(A, 0, 1, 0, SATURATE, 0, 0, 0,  0, 1, 1, 1, "t4 sat down again");
        step(A, 0, 0, 0, SATURATE, 0, 0, 1,  0, 0, 0, 0, "t4 clr both");

        // 6: reset mid-count with flags set
        step(A, 0, 0, 1, WRAP, 1, 9, 0,  9, 0, 0, 0, "t6 load9");
        step(A, 0, 1, 1, WRAP, 0, 0, 0,  0, 1, 1, 0, "t6 wrap");
        for (int i = 1; i <= 5; i++)
            step(A, 0, 1, 1, WRAP, 0, 0, 0, 4'(i), 0, 1, 0, $sformatf("t6 up%0d", i));
        step(A, 1, 1, 1, WRAP, 0, 0, 0,  0, 0, 0, 0, "t6 reset");
        step(A, 0, 1, 1, WRAP, 0, 0, 0,  1, 0, 0, 0, "t6 after reset");
        step(A, 0, 0, 1, WRAP, 0, 0, 0,  1, 0, 0, 0, "t6 idle");

        // 5: prescaler DIV=3, STEP=2
        step(B, 1, 0, 1, WRAP, 0, 0, 0,  0, 0, 0, 0, "t5 reset");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  0, 0, 0, 0, "t5 en1");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  0, 0, 0, 0, "t5 en2");
        step(B, 0, 0, 1, WRAP, 0, 0, 0,  0, 0, 0, 0, "t5 gap");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  2, 0, 0, 0, "t5 en3");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  2, 0, 0, 0, "t5 en4");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  2, 0, 0, 0, "t5 en5");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  4, 0, 0, 0, "t5 en6");
        step(B, 0, 0, 1, WRAP, 1, 9, 0,  9, 0, 0, 0, "t5 load9");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  9, 0, 0, 0, "t5 up a");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  9, 0, 0, 0, "t5 up b");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  1, 1, 1, 0, "t5 up wrap");
        step(B, 0, 0, 0, WRAP, 1, 1, 0,  1, 0, 1, 0, "t5 load1");
        step(B, 0, 1, 0, WRAP, 0, 0, 0,  1, 0, 1, 0, "t5 dn a");
        step(B, 0, 1, 0, WRAP, 0, 0, 0,  1, 0, 1, 0, "t5 dn b");
        step(B, 0, 1, 0, WRAP, 0, 0, 0,  9, 1, 1, 1, "t5 dn wrap");
        step(B, 0, 0, 1, WRAP, 1, 0, 0,  0, 0, 1, 1, "t5 load0");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  0, 0, 1, 1, "t5 pre a");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  0, 0, 1, 1, "t5 pre b");
        step(B, 0, 1, 1, WRAP, 1, 0, 0,  0, 0, 1, 1, "t5 load clears pre");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  0, 0, 1, 1, "t5 post a");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  0, 0, 1, 1, "t5 post b");
        step(B, 0, 1, 1, WRAP, 0, 0, 0,  2, 0, 1, 1, "t5 post c");
        step(B, 0, 0, 1, WRAP, 0, 0, 0,  2, 0, 1, 1, "t5 idle");

        // Drain the scoreboard within a fixed cycle budget.
        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
